// File: rtl/controle_multiciclo.sv
// controle_multiciclo -- multi-cycle control unit for the Redux-V core.
//
// Each instruction goes through FETCH, DECODE, EXEC and then, depending on its class,
// MEM and/or WB. A watchdog counts memory request cycles that have no acknowledge and
// parks the unit in ERR if memory stays silent too long.
//
// Ports:
//   clk, rst_n           clock, synchronous active-low reset
//   run                  keep executing; looked at only on instruction boundaries
//   opcode[3:0]          IR opcode, captured in DECODE
//   mem_ack              memory done; only meaningful while mem_req=1
//   mem_req              memory request (instruction fetch or data access)
//   ir_we                IR load pulse (FETCH with ack)
//   pc_we, instr_done    pulse on the last cycle of every instruction
//   b_mx j_mx r_mx se_mx d_mx, ula[ULA_W-1:0]
//                        datapath controls, valid in EXEC/MEM/WB, 0 elsewhere
//   we                   data memory write (MEM, store)
//   re                   register file write (WB)
//   busy                 1 outside IDLE and ERR
//   timeout_err          sticky watchdog error, cleared only by reset
//   state[2:0]           current FSM state (IDLE=0 .. ERR=6)
//
// Handshake: mem_req is held high for as long as the access lasts; the access completes
// on the rising edge where mem_req=1 and mem_ack=1. mem_ack while mem_req=0 is ignored.
module controle_multiciclo #(
    parameter int ULA_W   = 4,
    parameter int TO_W    = 4,
    parameter int TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic [3:0]       opcode,
    input  logic             mem_ack,
    output logic             mem_req,
    output logic             ir_we,
    output logic             pc_we,
    output logic             b_mx,
    output logic             j_mx,
    output logic             r_mx,
    output logic             se_mx,
    output logic             d_mx,
    output logic [ULA_W-1:0] ula,
    output logic             we,
    output logic             re,
    output logic             instr_done,
    output logic             busy,
    output logic             timeout_err,
    output logic [2:0]       state
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        MEM    = 3'd4,
        WB     = 3'd5,
        ERR    = 3'd6
    } state_t;

    // Counter value seen during the TIMEOUT-th unacked request cycle.
    localparam logic [TO_W-1:0] LIMIT = TO_W'(TIMEOUT - 1);

    state_t          state_q, state_d;
    logic [3:0]      op_q, op_d;
    logic [TO_W-1:0] cnt_q, cnt_d;

    // Opcode class decode from the latched op.
    logic       is_bj, is_load, is_store;
    logic       dec_b, dec_j, dec_r, dec_se, dec_d;
    logic [3:0] dec_ula;

    always_comb begin
        is_bj    = (op_q[3:1] == 3'b000);
        is_load  = (op_q == 4'b0010);
        is_store = (op_q == 4'b0011);
        dec_b    = (op_q == 4'b0000);
        dec_j    = (op_q == 4'b0001);
        dec_r    = (op_q[3:1] == 3'b010);
        dec_se   = (op_q[3:1] == 3'b010);
        dec_d    = op_q[3] | op_q[2];
        dec_ula  = 4'b0000;
        if (op_q[3]) begin
            dec_ula = {1'b0, op_q[2:0]};
        end else if (op_q[2:1] == 2'b10) begin
            dec_ula = op_q;
        end else if (op_q[2:1] == 2'b11) begin
            dec_ula = {3'b100, op_q[0]};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            op_q    <= 4'b0000;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
        end
    end

    logic in_dp, req_c, irw_c, fin_c, we_c, re_c;

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        req_c   = 1'b0;
        irw_c   = 1'b0;
        fin_c   = 1'b0;
        we_c    = 1'b0;
        re_c    = 1'b0;
        in_dp   = 1'b0;
        case (state_q)
            IDLE: begin
                if (run) begin
                    state_d = FETCH;
                    cnt_d   = '0;
                end
            end
            FETCH: begin
                req_c = 1'b1;
                if (mem_ack) begin
                    irw_c   = 1'b1;
                    state_d = DECODE;
                end else if (cnt_q == LIMIT) begin
                    state_d = ERR;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DECODE: begin
                op_d    = opcode;
                state_d = EXEC;
            end
            EXEC: begin
                in_dp = 1'b1;
                if (is_bj) begin
                    fin_c = 1'b1;
                end else if (is_load || is_store) begin
                    state_d = MEM;
                    cnt_d   = '0;
                end else begin
                    state_d = WB;
                end
            end
            MEM: begin
                in_dp = 1'b1;
                req_c = 1'b1;
                we_c  = is_store;
                if (mem_ack) begin
                    if (is_store) begin
                        fin_c = 1'b1;
                    end else begin
                        state_d = WB;
                    end
                end else if (cnt_q == LIMIT) begin
                    state_d = ERR;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            WB: begin
                in_dp = 1'b1;
                re_c  = 1'b1;
                fin_c = 1'b1;
            end
            ERR: begin
                state_d = ERR;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // Instruction boundary: chain straight into the next fetch while run stays high.
        if (fin_c) begin
            state_d = run ? FETCH : IDLE;
            cnt_d   = '0;
        end
    end

    // Pulses are suppressed while reset is asserted so nothing fires on the reset edge.
    assign mem_req     = req_c;
    assign ir_we       = irw_c & rst_n;
    assign pc_we       = fin_c & rst_n;
    assign instr_done  = fin_c & rst_n;
    assign we          = we_c;
    assign re          = re_c;
    assign b_mx        = in_dp & dec_b;
    assign j_mx        = in_dp & dec_j;
    assign r_mx        = in_dp & dec_r;
    assign se_mx       = in_dp & dec_se;
    assign d_mx        = in_dp & dec_d;
    assign ula         = in_dp ? ULA_W'(dec_ula) : '0;
    assign busy        = (state_q != IDLE) && (state_q != ERR);
    assign timeout_err = (state_q == ERR);
    assign state       = state_q;

endmodule
